// File: rtl/interrupt_context_pusher_if.sv
// Interrupt context pusher bus: interrupt handshake, pipeline status,
// data-memory write port, stack-pointer update and PC redirect.
interface interrupt_context_pusher_if #(
    parameter int FLAG_W = 3
);
    logic              int_req;
    logic              pipeline_empty;
    logic [31:0]       return_pc;
    logic [FLAG_W-1:0] flag_register;
    logic [15:0]       sp_in;
    logic              mem_ack;
    logic              stall_fetch;
    logic              mem_wr_en;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic              sp_wr;
    logic [15:0]       sp_out;
    logic              pc_load;
    logic [31:0]       pc_load_value;
    logic              int_ack;
    logic              busy;

    // Side seen by the pusher itself
    modport slave (
        input  int_req, pipeline_empty, return_pc, flag_register, sp_in, mem_ack,
        output stall_fetch, mem_wr_en, mem_addr, mem_wdata, sp_wr, sp_out,
               pc_load, pc_load_value, int_ack, busy
    );

    // Side seen by the core / memory environment
    modport master (
        output int_req, pipeline_empty, return_pc, flag_register, sp_in, mem_ack,
        input  stall_fetch, mem_wr_en, mem_addr, mem_wdata, sp_wr, sp_out,
               pc_load, pc_load_value, int_ack, busy
    );
endinterface

// File: rtl/interrupt_context_pusher.sv
// Interrupt entry sequencer: stalls fetch, waits for the pipeline to drain,
// pushes {PC hi, PC lo, flags} onto the data-memory stack, then updates SP
// and redirects the PC to the interrupt vector.
module interrupt_context_pusher #(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0002,
    parameter int          FLAG_W     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    interrupt_context_pusher_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DRAIN      = 3'd1,
        PUSH_PC_HI = 3'd2,
        PUSH_PC_LO = 3'd3,
        PUSH_FLAGS = 3'd4,
        VECTOR     = 3'd5
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [31:0]       pc_reg;
    logic [FLAG_W-1:0] flags_reg;
    logic [15:0]       sp_reg;
    logic              snapshot;
    logic [15:0]       flags_word;

    // Context is captured on the same edge that leaves DRAIN
    assign snapshot = (state_reg == DRAIN) && bus.pipeline_empty;

    // Zero-extend the saved flags to a full stack word; bits [2:0] feed the pop path
    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_flag_word
        if (gi < FLAG_W) begin : g_bit
            assign flags_word[gi] = flags_reg[gi];
        end else begin : g_zero
            assign flags_word[gi] = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Context snapshot registers (PC, flags, SP)
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= '0;
            flags_reg <= '0;
            sp_reg    <= '0;
        end else if (snapshot) begin
            pc_reg    <= bus.return_pc;
            flags_reg <= bus.flag_register;
            sp_reg    <= bus.sp_in;
        end
    end

    // Next-state logic: each sampled ack advances exactly one push
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (bus.int_req)        state_next = DRAIN;
            DRAIN:      if (bus.pipeline_empty) state_next = PUSH_PC_HI;
            PUSH_PC_HI: if (bus.mem_ack)        state_next = PUSH_PC_LO;
            PUSH_PC_LO: if (bus.mem_ack)        state_next = PUSH_FLAGS;
            PUSH_FLAGS: if (bus.mem_ack)        state_next = VECTOR;
            VECTOR:                             state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Output decode: write port held stable per push; stack grows downward
    always_comb begin
        bus.stall_fetch   = 1'b0;
        bus.busy          = 1'b0;
        bus.mem_wr_en     = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.sp_wr         = 1'b0;
        bus.sp_out        = '0;
        bus.pc_load       = 1'b0;
        bus.pc_load_value = '0;
        bus.int_ack       = 1'b0;
        case (state_reg)
            IDLE: begin
            end
            DRAIN: begin
                bus.stall_fetch = 1'b1;
                bus.busy        = 1'b1;
            end
            PUSH_PC_HI: begin
                bus.stall_fetch = 1'b1;
                bus.busy        = 1'b1;
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = sp_reg;
                bus.mem_wdata   = pc_reg[31:16];
            end
            PUSH_PC_LO: begin
                bus.stall_fetch = 1'b1;
                bus.busy        = 1'b1;
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = sp_reg - 16'd1;
                bus.mem_wdata   = pc_reg[15:0];
            end
            PUSH_FLAGS: begin
                bus.stall_fetch = 1'b1;
                bus.busy        = 1'b1;
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = sp_reg - 16'd2;
                bus.mem_wdata   = flags_word;
            end
            VECTOR: begin
                bus.stall_fetch   = 1'b1;
                bus.busy          = 1'b1;
                bus.sp_wr         = 1'b1;
                bus.sp_out        = sp_reg - 16'd3;
                bus.pc_load       = 1'b1;
                bus.pc_load_value = INT_VECTOR;
                bus.int_ack       = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: doc/interrupt_context_pusher.md
Name: interrupt_context_pusher

Overview:
- Sequential writer side of the flag/PC pop path. On an external interrupt it stalls fetch and waits for the pipeline to drain.
- It then pushes the return PC (two 16-bit words) and the 3-bit flag register {carry, negative, zero} onto the data-memory stack.
- Finally it updates SP and redirects the PC to the interrupt vector.
- RTI later pops these words in reverse order. The popped flags word feeds the ALU's memory-pop flag path via bits [2:0].

Parameters:
- INT_VECTOR, 32'h0000_0002, PC value loaded after the context is saved.
- FLAG_W, 3, width of flag register saved ({carry, negative, zero}).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- int_req  in  1  interrupt request; sampled only in IDLE.
- pipeline_empty  in  1  high when no older instruction remains in EX/MEM/WB.
- return_pc  in  32  PC to resume at after RTI.
- flag_register  in  3  current {carry, negative, zero}.
- sp_in  in  16  current stack pointer (points to next free word).
- mem_ack  in  1  data memory accepted the current write.
- stall_fetch  out  1  freeze fetch/decode while servicing.
- mem_wr_en  out  1  write request to data memory.
- mem_addr  out  16  write address.
- mem_wdata  out  16  write data.
- sp_wr  out  1  one-cycle strobe: load sp_out into SP.
- sp_out  out  16  new stack pointer.
- pc_load  out  1  one-cycle strobe: load pc_load_value into PC.
- pc_load_value  out  32  always INT_VECTOR when pc_load=1.
- int_ack  out  1  one-cycle acknowledge, coincident with pc_load.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE. All outputs 0. Latched pc/flags/sp cleared. Reset mid-sequence aborts immediately: no sp_wr, no pc_load, no further mem writes. Any partially written stack words are abandoned.
- States: IDLE, DRAIN, PUSH_PC_HI, PUSH_PC_LO, PUSH_FLAGS, VECTOR.
- IDLE:
  - int_req=1 -> DRAIN next cycle. Otherwise stay.
  - mem_ack is ignored.
- DRAIN:
  - stall_fetch=1, busy=1.
  - When pipeline_empty=1, latch return_pc, flag_register, sp_in in the same edge -> PUSH_PC_HI.
  - If pipeline_empty is already 1 on DRAIN entry, DRAIN lasts exactly one cycle.
- PUSH_PC_HI:
  - mem_wr_en=1, mem_addr=sp_l, mem_wdata=pc_l[31:16].
  - Outputs are held stable until mem_ack=1 is sampled, then -> PUSH_PC_LO.
- PUSH_PC_LO: same handshake, mem_addr=sp_l-1, mem_wdata=pc_l[15:0]. On ack -> PUSH_FLAGS.
- PUSH_FLAGS: same handshake, mem_addr=sp_l-2, mem_wdata={13'b0, flags_l}. On ack -> VECTOR.
- VECTOR:
  - One cycle. pc_load=1, pc_load_value=INT_VECTOR, int_ack=1, sp_wr=1, sp_out=sp_l-3.
  - stall_fetch remains 1 this cycle. Next state IDLE.
- stall_fetch=1 in DRAIN through VECTOR inclusive; 0 in IDLE. mem_wr_en=1 only in the PUSH states.
- Minimum latency with immediate ack and an empty pipeline: int_req sampled at edge N; pc_load at cycle N+5.
- mem_ack is one-cycle or held; each high-sampled cycle advances exactly one push. Ack in a non-PUSH state is ignored.
- Stack arithmetic is 16-bit modulo 2^16. Example: sp=0x0001 -> addresses 0x0001, 0x0000, 0xFFFF; sp_out=0xFFFE.
- int_req outside IDLE is ignored (not queued). The requester drops int_req on int_ack. If int_req is still high in the IDLE cycle after VECTOR, a new sequence starts.
- Flags and PC are snapshotted only at DRAIN exit. Later changes to flag_register/return_pc/sp_in do not affect pushed data.

Test Plan:
- Nominal: reset, sp_in=0x03FF, return_pc=0x0001_2345, flags=3'b101, pipeline_empty=1, mem_ack tied 1, int_req pulse. Required writes: [0x03FF]=0x0001, [0x03FE]=0x2345, [0x03FD]=0x0005. Then sp_out=0x03FC with sp_wr=1, pc_load_value=0x0000_0002, int_ack=1, five cycles after the request edge.
- Drain wait: pipeline_empty held 0 for 4 cycles while flags change 3'b000->3'b011. Required: stall_fetch high throughout, no mem_wr_en until empty, pushed flags word = the value at drain exit.
- Ack backpressure: mem_ack low 3 cycles on each push. Required: mem_addr/mem_wdata stable while waiting, exactly 3 writes, no duplicate advance.
- Wrap: sp_in=0x0001. Required: addresses 0x0001, 0x0000, 0xFFFF; sp_out=0xFFFE.
- Reset mid-op: assert rst during PUSH_PC_LO. Required: next cycle all outputs 0, state IDLE, no sp_wr/pc_load ever issued for that request.
- Request while busy: second int_req pulse during PUSH_FLAGS. Required: ignored; exactly one int_ack; busy drops after VECTOR.
